// File: rtl/yarp_pkg.sv
// Shared encodings for the yarp core: memory access sizes and the LSU state machine.
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b11
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE,
    LD_REQ,
    LD_DATA,
    RMW_RD,
    RMW_MERGE,
    ST_WR,
    RESP
  } lsu_state_t;

  // Misaligned halfword/word accesses and the unused size code 2'b10 are rejected.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    err = 1'b0;
    if (size == 2'b10) err = 1'b1;
    else if (size == HALF_WORD && off[0]) err = 1'b1;
    else if (size == WORD && off != 2'b00) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/yarp_lsu_align.sv
// Lane handling for the LSU: load extraction/extension and sub-word store merge.
module yarp_lsu_align
  import yarp_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        zero_extnd,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rd_word[{off, 3'b000} +: 8];
    half_lane = rd_word[{off[1], 4'b0000} +: 16];
    ld_data   = rd_word;
    case (size)
      BYTE:      ld_data = zero_extnd ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      HALF_WORD: ld_data = zero_extnd ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default:   ld_data = rd_word;
    endcase
  end

  // Halfword offsets are already known to be even, so off[1] picks the lane pair.
  always_comb begin
    st_word = rd_word;
    case (size)
      BYTE:      st_word[{off, 3'b000} +: 8]     = wdata[7:0];
      HALF_WORD: st_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default:   st_word = wdata;
    endcase
  end

endmodule

// File: rtl/yarp_lsu.sv
// Load/store unit: turns core loads/stores into word-wide data_mem accesses,
// doing lane extraction on loads and read-modify-write on sub-word stores.
module yarp_lsu
  import yarp_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_zero_extnd_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wr_data_o,
  output logic [1:0]  data_byte_en_o,
  output logic        data_zero_extnd_o,
  input  logic [31:0] data_mem_rd_data_i
);

  // Handshake: a request transfers on a rising edge where req_valid_i && req_ready_o;
  // req_ready_o is high only in IDLE, so a busy unit leaves the core holding its request.
  // rsp_valid_o is a single-cycle pulse with no back-pressure.

  lsu_state_t  state;
  lsu_state_t  state_nxt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        wr_q;
  logic        zext_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] wr_word_q;
  logic [31:0] ld_data;
  logic [31:0] st_word;
  logic        accept;

  assign accept = req_valid_i && req_ready_o;

  yarp_lsu_align u_align (
    .rd_word    (data_mem_rd_data_i),
    .off        (addr_q[1:0]),
    .size       (size_q),
    .zero_extnd (zext_q),
    .wdata      (wdata_q),
    .ld_data    (ld_data),
    .st_word    (st_word)
  );

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      wr_q      <= 1'b0;
      zext_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      wr_word_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q    <= req_addr_i;
        wdata_q   <= req_wdata_i;
        size_q    <= req_size_i;
        wr_q      <= req_wr_i;
        zext_q    <= req_zero_extnd_i;
        err_q     <= access_err(req_size_i, req_addr_i[1:0]);
        rdata_q   <= '0;
        wr_word_q <= req_wdata_i;
      end
      if (state == LD_DATA) rdata_q <= ld_data;
      if (state == RMW_MERGE) wr_word_q <= st_word;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    data_req_o  = 1'b0;
    data_wr_o   = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (access_err(req_size_i, req_addr_i[1:0])) state_nxt = RESP;
          else if (!req_wr_i)                           state_nxt = LD_REQ;
          else if (req_size_i == WORD)                  state_nxt = ST_WR;
          else                                          state_nxt = RMW_RD;
        end
      end
      LD_REQ: begin
        data_req_o = 1'b1;
        state_nxt  = LD_DATA;
      end
      LD_DATA:   state_nxt = RESP;
      RMW_RD: begin
        data_req_o = 1'b1;
        state_nxt  = RMW_MERGE;
      end
      RMW_MERGE: state_nxt = ST_WR;
      ST_WR: begin
        data_req_o = 1'b1;
        data_wr_o  = 1'b1;
        state_nxt  = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side outputs come only from registered state, never from req_*.
  assign data_addr_o       = {addr_q[31:2], 2'b00};
  assign data_wr_data_o    = (state == ST_WR) ? wr_word_q : '0;
  assign data_byte_en_o    = WORD;
  assign data_zero_extnd_o = 1'b1;
  assign rsp_rdata_o       = rdata_q;

endmodule

// File: tb/tb_yarp_lsu.sv
// Self-checking bench for yarp_lsu: directed scenarios plus random traffic
// against a word-array memory and an arithmetic reference model.
module tb_yarp_lsu;
  import yarp_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wr_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        req_zero_extnd_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        data_req_o;
  logic        data_wr_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wr_data_o;
  logic [1:0]  data_byte_en_o;
  logic        data_zero_extnd_o;
  logic [31:0] data_mem_rd_data_i;

  yarp_lsu dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_wr_i           (req_wr_i),
    .req_addr_i         (req_addr_i),
    .req_wdata_i        (req_wdata_i),
    .req_size_i         (req_size_i),
    .req_zero_extnd_i   (req_zero_extnd_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_rdata_o        (rsp_rdata_o),
    .rsp_err_o          (rsp_err_o),
    .data_req_o         (data_req_o),
    .data_wr_o          (data_wr_o),
    .data_addr_o        (data_addr_o),
    .data_wr_data_o     (data_wr_data_o),
    .data_byte_en_o     (data_byte_en_o),
    .data_zero_extnd_o  (data_zero_extnd_o),
    .data_mem_rd_data_i (data_mem_rd_data_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory ----------------
  // Unwritten words read as a fixed pattern; 0x100 holds the test-plan word.
  function automatic logic [31:0] init_word(input int idx);
    if (idx == 32'h40) return 32'h80FF_7F01;
    return (idx * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  logic [31:0] mem_arr [0:255];
  bit          mem_written [0:255];
  logic [31:0] rd_q;
  int          rd_cnt;
  int          wr_cnt;
  int          addr_bad;
  logic [31:0] exp_word_addr;

  function automatic logic [31:0] mem_word(input int idx);
    return mem_written[idx] ? mem_arr[idx] : init_word(idx);
  endfunction

  always @(posedge clk) begin
    if (data_req_o === 1'b1) begin
      if (data_addr_o !== exp_word_addr) addr_bad++;
      if (data_wr_o === 1'b1) begin
        mem_arr[data_addr_o[9:2]]     = data_wr_data_o;
        mem_written[data_addr_o[9:2]] = 1'b1;
        wr_cnt++;
      end else begin
        rd_q <= mem_word(int'(data_addr_o[9:2]));
        rd_cnt++;
      end
    end
  end
  assign data_mem_rd_data_i = rd_q;

  // ---------------- reference model ----------------
  logic [31:0] model_mem [0:255];

  function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b10) || (size == 2'b01 && addr[0]) || (size == 2'b11 && addr[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] addr,
                                           input logic [1:0] size, input logic zext);
    int sh;
    logic [31:0] v;
    sh = 8 * int'(addr[1:0]);
    if (size == 2'b00) begin
      v = (w >> sh) & 32'hFF;
      if (!zext && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = (w >> sh) & 32'hFFFF;
      if (!zext && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] addr,
                                            input logic [1:0] size, input logic [31:0] wd);
    int sh;
    logic [31:0] mask;
    sh = 8 * int'(addr[1:0]);
    if (size == 2'b11) return wd;
    mask = (size == 2'b00) ? 32'hFF : 32'hFFFF;
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];
  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Starts and returns on a negative edge; on return the response outputs are still visible.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic zext, input bit keep,
                        input int exp_wait);
    int          wait_n, lat, r0, w0, b0, busy_rdy, exp_lat, exp_r, exp_w, idx;
    bit          err;
    logic [31:0] exp_rd, exp_new;
    idx     = int'(addr[9:2]);
    err     = ref_err(size, addr);
    exp_rd  = (err || wr) ? 32'h0 : ref_load(model_mem[idx], addr, size, zext);
    exp_new = ref_store(model_mem[idx], addr, size, wdata);
    if (err)                begin exp_lat = 1; exp_r = 0; exp_w = 0; end
    else if (!wr)           begin exp_lat = 3; exp_r = 1; exp_w = 0; end
    else if (size == 2'b11) begin exp_lat = 2; exp_r = 0; exp_w = 1; end
    else                    begin exp_lat = 4; exp_r = 1; exp_w = 1; end
    exp_q.push_back(exp_rd);
    exp_word_addr    = {addr[31:2], 2'b00};
    req_wr_i         = wr;
    req_addr_i       = addr;
    req_wdata_i      = wdata;
    req_size_i       = size;
    req_zero_extnd_i = zext;
    req_valid_i      = 1'b1;
    wait_n = 0;
    while (req_ready_o !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    if (wait_n >= 20) begin
      check("accept_timeout", 32'(wait_n), 32'(exp_wait));
      req_valid_i = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    if (exp_wait >= 0) check("accept_wait", 32'(wait_n), 32'(exp_wait));
    r0 = rd_cnt; w0 = wr_cnt; b0 = addr_bad;
    @(posedge clk);
    lat = 0; busy_rdy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !keep) req_valid_i = 1'b0;
      if (rsp_valid_o !== 1'b1 && req_ready_o !== 1'b0) busy_rdy++;
    end while (rsp_valid_o !== 1'b1 && lat < 20);
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_err", {31'b0, rsp_err_o}, {31'b0, err});
    check("rsp_rdata", rsp_rdata_o, exp_q.pop_front());
    check("ready_busy", 32'(busy_rdy), 32'd0);
    check("mem_reads", 32'(rd_cnt - r0), 32'(exp_r));
    check("mem_writes", 32'(wr_cnt - w0), 32'(exp_w));
    check("mem_addr", 32'(addr_bad - b0), 32'd0);
    if (wr && !err) begin
      model_mem[idx] = exp_new;
      check("mem_word", mem_word(idx), exp_new);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          r0, w0, r;
    logic        wr, zext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    exp_word_addr    = '0;
    req_valid_i      = 1'b0;
    req_wr_i         = 1'b0;
    req_addr_i       = '0;
    req_wdata_i      = '0;
    req_size_i       = 2'b00;
    req_zero_extnd_i = 1'b0;
    reset_n          = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready_o}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'd0);
    check("rst_err", {31'b0, rsp_err_o}, 32'd0);
    check("rst_data_req", {31'b0, data_req_o}, 32'd0);
    check("rst_data_wr", {31'b0, data_wr_o}, 32'd0);
    check("rst_data_addr", data_addr_o, 32'd0);
    check("rst_wr_data", data_wr_data_o, 32'd0);
    check("rst_byte_en", {30'b0, data_byte_en_o}, 32'd3);
    check("rst_zext", {31'b0, data_zero_extnd_o}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);

    // Loads from the 0x80FF_7F01 word at 0x100.
    do_req(1'b0, 32'h103, 32'h0, BYTE, 1'b0, 1'b0, 0);
    check("lb_plan", rsp_rdata_o, 32'hFFFF_FF80);
    do_req(1'b0, 32'h103, 32'h0, BYTE, 1'b1, 1'b0, -1);
    check("lbu_plan", rsp_rdata_o, 32'h0000_0080);
    do_req(1'b0, 32'h102, 32'h0, HALF_WORD, 1'b0, 1'b0, -1);
    check("lh_plan", rsp_rdata_o, 32'hFFFF_80FF);

    // Byte store read-modify-write.
    do_req(1'b1, 32'h101, 32'hAB, BYTE, 1'b0, 1'b0, -1);
    check("sb_plan", mem_word(32'h40), 32'h80FF_AB01);

    // Misaligned / illegal.
    do_req(1'b0, 32'h102, 32'h0, WORD, 1'b0, 1'b0, -1);
    check("lw_mis_err", {31'b0, rsp_err_o}, 32'd1);
    do_req(1'b0, 32'h101, 32'h0, HALF_WORD, 1'b0, 1'b0, -1);
    do_req(1'b1, 32'h100, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, -1);

    // Back-to-back with valid held through the first transaction.
    do_req(1'b1, 32'h200, 32'h1234_5678, WORD, 1'b0, 1'b1, -1);
    do_req(1'b0, 32'h200, 32'h0, WORD, 1'b0, 1'b0, 1);
    check("b2b_lw", rsp_rdata_o, 32'h1234_5678);

    // Reset while in RMW_MERGE: no write, no response.
    @(negedge clk);
    exp_word_addr    = 32'h300;
    req_wr_i         = 1'b1;
    req_addr_i       = 32'h301;
    req_wdata_i      = 32'h5A;
    req_size_i       = BYTE;
    req_zero_extnd_i = 1'b0;
    req_valid_i      = 1'b1;
    check("rmw_rst_ready_pre", {31'b0, req_ready_o}, 32'd1);
    r0 = rd_cnt; w0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rmw_rst_ready", {31'b0, req_ready_o}, 32'd1);
      check("rmw_rst_rsp", {31'b0, rsp_valid_o}, 32'd0);
      check("rmw_rst_req", {31'b0, data_req_o}, 32'd0);
    end
    reset_n = 1'b0;
    @(negedge clk);
    check("rmw_rst_reads", 32'(rd_cnt - r0), 32'd1);
    check("rmw_rst_writes", 32'(wr_cnt - w0), 32'd0);
    check("rmw_rst_mem", mem_word(32'hC0), model_mem[32'hC0]);
    do_req(1'b0, 32'h300, 32'h0, WORD, 1'b0, 1'b0, 0);

    // Random traffic over sixteen words.
    for (int n = 0; n < 60; n++) begin
      wr    = 1'($urandom_range(0, 1));
      zext  = 1'($urandom_range(0, 1));
      wdata = $urandom;
      r     = $urandom_range(0, 9);
      size  = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b11 : 2'b10;
      addr  = 32'h300 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) addr = addr & ~{30'b0, size[0], size[0] & size[1]};
      do_req(wr, addr, wdata, size, zext, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/yarp_lsu.md
# yarp_lsu

Load/store unit for the yarp RV32I core. Sits between the execute stage and `data_mem`, acting as the initiator on the data-memory port. The memory port only moves full words correctly at arbitrary byte offsets, so the unit turns every core load into a word read plus lane extraction and sign/zero extension. Every sub-word store becomes a read-modify-write. Misaligned and illegal accesses are flagged without touching memory.

## Interface
Parameters:
- none; sizes and encodings come from `yarp_pkg`.

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `reset_n` in 1 — asynchronous, active-high: asserted when 1, despite the codebase port name.
- `req_valid_i` in 1 — core request valid.
- `req_ready_o` out 1 — unit can accept a request; high only in IDLE.
- `req_wr_i` in 1 — 1 = store, 0 = load.
- `req_addr_i` in 32 — byte address.
- `req_wdata_i` in 32 — store data, right-aligned.
- `req_size_i` in 2 — BYTE / HALF_WORD / WORD.
- `req_zero_extnd_i` in 1 — 1 = LBU/LHU, 0 = sign extend.
- `rsp_valid_o` out 1 — one-cycle completion pulse, for loads and stores.
- `rsp_rdata_o` out 32 — extended load result; 0 for stores and errors.
- `rsp_err_o` out 1 — misaligned or illegal size; qualified by `rsp_valid_o`.
- `data_req_o` out 1 — memory request.
- `data_wr_o` out 1 — memory write.
- `data_addr_o` out 32 — word-aligned address `{addr[31:2],2'b00}`.
- `data_wr_data_o` out 32 — full word to write.
- `data_byte_en_o` out 2 — constant WORD.
- `data_zero_extnd_o` out 1 — constant 1.
- `data_mem_rd_data_i` in 32 — memory read data, valid the cycle after a read request.

## Operation
- **Accept:** a request is accepted on an edge where `req_valid_i & req_ready_o`. Address, data, size, wr and zero-extend are captured into registers.
- **Error check at accept:**
  - HALF_WORD with `addr[0]=1` is an error.
  - WORD with `addr[1:0]!=0` is an error.
  - Size 2'b10 is an error.
  - On error: go to RESP with `rsp_err_o=1`; no memory request is issued.
- **States:**
  - IDLE: on accept, go to LD_REQ (load), ST_WR (word store), RMW_RD (sub-word store) or RESP (error).
  - LD_REQ: `data_req_o=1`, `data_wr_o=0` → LD_DATA.
  - LD_DATA: capture the extracted and extended word → RESP.
  - RMW_RD: `data_req_o=1`, `data_wr_o=0` → RMW_MERGE.
  - RMW_MERGE: merge `wdata[7:0]` into lane `off`, or `wdata[15:0]` into lanes `off..off+1`, of the read word; register the result → ST_WR.
  - ST_WR: `data_req_o=1`, `data_wr_o=1`, `data_wr_data_o` = full or merged word → RESP.
  - RESP: `rsp_valid_o=1` → IDLE.
- **Extraction:** lane selected by `off = addr[1:0]`. Byte = `word[8*off+7:8*off]`; half = `word[16*off[1]+15:16*off[1]]`. Extend per the captured zero-extend bit.
- **Memory port outputs** are decoded from the state register and captured registers only. There is no combinational path from `req_*` to `data_*`.

## Timing
- **Reset values:**
  - state IDLE
  - `req_ready_o=1`
  - `rsp_valid_o=0`, `rsp_rdata_o=0`, `rsp_err_o=0`
  - `data_req_o=0`, `data_wr_o=0`, `data_addr_o=0`, `data_wr_data_o=0`
  - `data_byte_en_o=WORD`, `data_zero_extnd_o=1`
- **Latency**, counting the accept edge as cycle 0 (`rsp_valid_o` high in):
  - load: cycle 3
  - word store: cycle 2
  - sub-word store: cycle 4
  - error: cycle 1
- After RESP, IDLE is re-entered, so the next accept happens at the earliest one cycle after the `rsp_valid_o` cycle.
- `req_ready_o` is low in every state except IDLE. Requests presented while busy are not consumed; the core holds them.
- **Reset mid-operation:** return immediately to IDLE with no response.
  - A write not yet in ST_WR is never issued.
  - A read-modify-write interrupted after RMW_RD leaves memory unchanged.

## Structure
- `yarp_pkg` holds:
  - `mem_size_t` with BYTE=2'b00, HALF_WORD=2'b01, WORD=2'b11.
  - `lsu_state_t` enum.
- Sub-module `yarp_lsu_align`, purely combinational, holds the extract/extend and merge functions, so both directions can be unit-tested separately.

## Test plan
- **LB sign-extend:** memory word @0x100 = 0x80FF_7F01; load BYTE addr 0x103, zero_extnd=0 → `rsp_rdata_o=0xFFFF_FF80`, cycle 3; LBU at the same address → 0x0000_0080.
- **LH:** load HALF_WORD addr 0x102 on the same word → 0xFFFF_80FF.
- **SB read-modify-write:** store BYTE 0xAB to 0x101 → exactly one read of 0x100 then one write of 0x80FF_AB01; `rsp_valid_o` at cycle 4.
- **Misaligned:** load WORD addr 0x102 → `rsp_err_o=1` at cycle 1, `data_req_o` never asserted; same for HALF_WORD addr 0x101 and for size 2'b10.
- **Back-to-back:** hold `req_valid_i` with SW 0x1234_5678 @0x200 then LW @0x200 → second request accepted only after the first response; load returns 0x1234_5678.
- **Reset mid-RMW:** assert `reset_n=1` in RMW_MERGE → no write, no `rsp_valid_o`, `req_ready_o=1` while reset is held.
